risc_datapath: RTL and testbench

Execution datapath for the 8-bit accumulator CPU, directly downstream of the instruction-sequencing controller. It consumes the controller's per-cycle strobes (`load_ir`, `load_ac`, `inc_pc`, `load_pc`, `mem_rd`, `mem_wr`, `halt`) and holds the architectural state: program counter, instruction register, accumulator and sticky halt flag. It returns `opcode` and `zero` to the controller and drives the single shared instruction/data memory port.

---
 rtl/risc_datapath_pkg.sv | 33 +++
 rtl/risc_datapath_alu.sv | 31 +++
 rtl/risc_datapath.sv | 148 ++++++++++++++
 tb/tb_risc_datapath.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_datapath_pkg.sv
// -----------------------------------------------------------------------------
// risc_datapath_pkg
// Shared types and default constants for the 8-bit accumulator CPU datapath.
//   opcode_t    : 3-bit instruction opcode (HLT..JMP = 0..7)
//   DEF_DATA_W  : default data / instruction width
//   DEF_ADDR_W  : default memory address width (always DATA_W-3)
//   DEF_CNT_W   : default retired-instruction counter width
//   OPC_W       : opcode field width at the top of the instruction word
// -----------------------------------------------------------------------------
package risc_datapath_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_CNT_W  = 16;
   localparam int OPC_W      = 3;

   typedef enum logic [OPC_W-1:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   // True for the opcodes that read an operand and write the accumulator.
   function automatic logic is_alu_op(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/risc_datapath_alu.sv
// -----------------------------------------------------------------------------
// risc_datapath_alu
// Combinational accumulator-update logic.
//   opcode : decoded opcode from the instruction register
//   accum  : current accumulator value
//   data   : operand read from memory
//   result : next accumulator value (accum unchanged for non-ALU opcodes)
// -----------------------------------------------------------------------------
module risc_datapath_alu
   import risc_datapath_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  opcode_t           opcode,
   input  logic [DATA_W-1:0] accum,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = accum;
      case (opcode)
         ADD:     result = accum + data;   // carry out is dropped
         AND:     result = accum & data;
         XOR:     result = accum ^ data;
         LDA:     result = data;
         default: result = accum;
      endcase
   end

endmodule

// File: rtl/risc_datapath.sv
// -----------------------------------------------------------------------------
// risc_datapath
// Execution datapath of the 8-bit accumulator CPU. Holds PC, IR, AC, the
// sticky halt flag, the operand-phase flag and a saturating retired-
// instruction counter, and drives the shared instruction/data memory port.
//
// Ports
//   clk, rst        : clock (posedge) and asynchronous active-high reset
//   load_ir, load_ac, inc_pc, load_pc, mem_rd, mem_wr, halt
//                   : per-cycle strobes from the sequencing controller
//   mem_rdata       : memory read data, combinational from mem_addr
//   opcode          : IR opcode field back to the controller
//   zero            : accumulator == 0
//   mem_addr        : PC in fetch phase, IR operand in operand phase
//   mem_wdata       : accumulator
//   mem_rd_en       : mem_rd passed through
//   mem_wr_en       : mem_wr suppressed once halted
//   halted          : sticky halt flag, cleared only by rst
//   instr_count     : retired instructions, saturating
//
// Handshake: there is no valid/ready flow here. Every strobe is a
// single-cycle command that takes effect at the posedge where it is sampled
// high; the controller owns all sequencing.
//
// ADDR_W must equal DATA_W-3 so the operand field exactly fills the
// instruction word below the opcode.
// -----------------------------------------------------------------------------
module risc_datapath
   import risc_datapath_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_ir,
   input  logic              load_ac,
   input  logic              inc_pc,
   input  logic              load_pc,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic              halt,
   input  logic [DATA_W-1:0] mem_rdata,
   output opcode_t           opcode,
   output logic              zero,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count
);

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] ac;
   logic [DATA_W-1:0] alu_result;
   logic [ADDR_W-1:0] operand;
   logic              op_phase;
   logic              load_ir_q;
   logic              strobes_idle;
   logic              load_ir_fell;
   logic              load_ir_rose;

   assign opcode  = opcode_t'(ir[DATA_W-1 -: OPC_W]);
   assign operand = ir[ADDR_W-1:0];

   // The instruction-address cycle is the only one where the controller
   // drives every strobe low; it marks the start of the next instruction.
   assign strobes_idle = ~(load_ir | load_ac | inc_pc | load_pc |
                           mem_rd | mem_wr | halt);

   // load_ir is held for two cycles per instruction, so edge detection on
   // its registered copy gives exactly one event per instruction.
   assign load_ir_fell = load_ir_q & ~load_ir;
   assign load_ir_rose = load_ir & ~load_ir_q;

   // ---------------------------------------------------------------- ALU
   risc_datapath_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .opcode (opcode),
      .accum  (ac),
      .data   (mem_rdata),
      .result (alu_result)
   );

   // ---------------------------------------------------- load_ir history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) load_ir_q <= 1'b0;
      else     load_ir_q <= load_ir;
   end

   // -------------------------------------------------------- phase flag
   // Clear takes priority so an idle cycle always returns the address mux
   // to the PC, even if a fall of load_ir is seen on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               op_phase <= 1'b0;
      else if (strobes_idle) op_phase <= 1'b0;
      else if (load_ir_fell) op_phase <= 1'b1;
   end

   // -------------------------------------------------------- instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ir <= '0;
      else if (load_ir) ir <= mem_rdata;
   end

   // -------------------------------------------------------- accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ac <= '0;
      else if (load_ac) ac <= alu_result;
   end

   // ---------------------------------------------------- program counter
   // Frozen once halted; load_pc beats inc_pc. Natural wrap at 2^ADDR_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          pc <= '0;
      else if (!halted) begin
         if (load_pc)     pc <= operand;
         else if (inc_pc) pc <= pc + ADDR_W'(1);
      end
   end

   // ------------------------------------------------------ halt (sticky)
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       halted <= 1'b0;
      else if (halt) halted <= 1'b1;
   end

   // ------------------------------------------ retired-instruction count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count <= '0;
      end else if (load_ir_rose && !halted && (instr_count != {CNT_W{1'b1}})) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

   // ------------------------------------------------------- memory port
   assign mem_addr  = op_phase ? operand : pc;
   assign mem_wdata = ac;
   assign mem_rd_en = mem_rd;
   assign mem_wr_en = mem_wr & ~halted;
   assign zero      = (ac == '0);

endmodule

// File: tb/tb_risc_datapath.sv
// -----------------------------------------------------------------------------
// tb_risc_datapath
// Drives the datapath with controller-like 8-cycle instruction sequences,
// raw random strobe patterns and asynchronous resets, and compares every
// output each cycle against an architectural model of the CPU state.
// A second instance with a 2-bit counter shares the stimulus to cover
// counter saturation.
// -----------------------------------------------------------------------------
module tb_risc_datapath;
   import risc_datapath_pkg::*;

   // ------------------------------------------------ clock / reset block
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ stimulus
   logic load_ir = 1'b0, load_ac = 1'b0, inc_pc = 1'b0, load_pc = 1'b0;
   logic mem_rd = 1'b0, mem_wr = 1'b0, halt = 1'b0;
   logic [7:0] mem [0:31];

   localparam logic [6:0] S_LDIR = 7'b1000000;
   localparam logic [6:0] S_LDAC = 7'b0100000;
   localparam logic [6:0] S_INC  = 7'b0010000;
   localparam logic [6:0] S_LDPC = 7'b0001000;
   localparam logic [6:0] S_RD   = 7'b0000100;
   localparam logic [6:0] S_WR   = 7'b0000010;
   localparam logic [6:0] S_HALT = 7'b0000001;

   // ------------------------------------------------------- DUT (CNT_W=16)
   logic [7:0]  mem_rdata, mem_wdata;
   logic [4:0]  mem_addr;
   opcode_t     opcode;
   logic        zero, mem_rd_en, mem_wr_en, halted;
   logic [15:0] instr_count;

   assign mem_rdata = mem[mem_addr];

   risc_datapath #(.DATA_W(8), .ADDR_W(5), .CNT_W(16)) u_dut (
      .clk (clk), .rst (rst),
      .load_ir (load_ir), .load_ac (load_ac), .inc_pc (inc_pc),
      .load_pc (load_pc), .mem_rd (mem_rd), .mem_wr (mem_wr), .halt (halt),
      .mem_rdata (mem_rdata), .opcode (opcode), .zero (zero),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en), .halted (halted), .instr_count (instr_count)
   );

   // -------------------------------------------------------- DUT (CNT_W=2)
   logic [7:0] sat_rdata, sat_wdata;
   logic [4:0] sat_addr;
   opcode_t    sat_opcode;
   logic       sat_zero, sat_rd_en, sat_wr_en, sat_halted;
   logic [1:0] sat_count;

   assign sat_rdata = mem[sat_addr];

   risc_datapath #(.DATA_W(8), .ADDR_W(5), .CNT_W(2)) u_sat (
      .clk (clk), .rst (rst),
      .load_ir (load_ir), .load_ac (load_ac), .inc_pc (inc_pc),
      .load_pc (load_pc), .mem_rd (mem_rd), .mem_wr (mem_wr), .halt (halt),
      .mem_rdata (sat_rdata), .opcode (sat_opcode), .zero (sat_zero),
      .mem_addr (sat_addr), .mem_wdata (sat_wdata), .mem_rd_en (sat_rd_en),
      .mem_wr_en (sat_wr_en), .halted (sat_halted), .instr_count (sat_count)
   );

   // ---------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------- behavioural model
   // Architectural CPU state: where the next memory access points, what the
   // accumulator holds, how many instructions have started.
   logic [4:0] m_pc = '0;
   logic [7:0] m_ir = '0;
   logic [7:0] m_ac = '0;
   bit         m_halted = 1'b0;
   bit         m_operand_phase = 1'b0;
   bit         m_prev_ld_ir = 1'b0;
   int         m_instrs = 0;

   function automatic logic [4:0] model_addr();
      return m_operand_phase ? m_ir[4:0] : m_pc;
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [7:0] rd;
      int         sum;
      if (rst) begin
         m_pc = '0; m_ir = '0; m_ac = '0;
         m_halted = 1'b0; m_operand_phase = 1'b0; m_prev_ld_ir = 1'b0;
         m_instrs = 0;
      end else begin
         rd = mem[model_addr()];
         if (load_ac) begin
            sum = int'(m_ac) + int'(rd);
            case (m_ir[7:5])
               3'd2: m_ac = 8'(sum % 256);
               3'd3: m_ac = m_ac & rd;
               3'd4: m_ac = m_ac ^ rd;
               3'd5: m_ac = rd;
               default: ;
            endcase
         end
         if (!m_halted) begin
            if (load_pc)     m_pc = m_ir[4:0];
            else if (inc_pc) m_pc = 5'((int'(m_pc) + 1) % 32);
         end
         if (load_ir && !m_prev_ld_ir && !m_halted) m_instrs++;
         if ({load_ir, load_ac, inc_pc, load_pc, mem_rd, mem_wr, halt} == 7'd0)
            m_operand_phase = 1'b0;
         else if (m_prev_ld_ir && !load_ir)
            m_operand_phase = 1'b1;
         if (load_ir) m_ir = rd;
         if (halt)    m_halted = 1'b1;
         m_prev_ld_ir = load_ir;
      end
   end

   // ------------------------------------------------------ compare process
   always @(negedge clk) begin
      check("opcode",    32'(opcode),      32'(m_ir[7:5]));
      check("zero",      32'(zero),        32'(m_ac == 8'd0));
      check("mem_addr",  32'(mem_addr),    32'(model_addr()));
      check("mem_wdata", 32'(mem_wdata),   32'(m_ac));
      check("mem_rd_en", 32'(mem_rd_en),   32'(mem_rd));
      check("mem_wr_en", 32'(mem_wr_en),   32'(mem_wr && !m_halted));
      check("halted",    32'(halted),      32'(m_halted));
      check("instr_cnt", 32'(instr_count), 32'(m_instrs > 65535 ? 65535 : m_instrs));
      check("sat_count", 32'(sat_count),   32'(m_instrs > 3 ? 3 : m_instrs));
   end

   // -------------------------------------------------------- driver tasks
   // Strobes change 1 time unit after the falling edge; on return the bench
   // sits at the next falling edge with the strobes still applied.
   task automatic step(input logic [6:0] s);
      #1;
      {load_ir, load_ac, inc_pc, load_pc, mem_rd, mem_wr, halt} = s;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Strobe pattern of cycle k of the controller's 8-cycle instruction.
   function automatic logic [6:0] ctrl(input int k, input logic [2:0] op, input bit z);
      logic [6:0] s;
      bit alu;
      alu = (op >= 3'd2) && (op <= 3'd5);
      s = 7'd0;
      case (k)
         1:       s = S_RD;
         2, 3:    s = S_RD | S_LDIR;
         4:       s = S_INC | ((op == 3'd0) ? S_HALT : 7'd0);
         5:       s = S_RD;
         6:       s = S_RD | (alu ? S_LDAC : 7'd0) | ((op == 3'd1 && z) ? S_INC : 7'd0)
                       | ((op == 3'd7) ? S_LDPC : 7'd0);
         7:       s = ((op == 3'd6) ? S_WR : S_RD) | ((op == 3'd7) ? S_LDPC : 7'd0);
         default: s = 7'd0;
      endcase
      return s;
   endfunction

   task automatic instr_cycle(input int k);
      step(ctrl(k, m_ir[7:5], m_ac == 8'd0));
   endtask

   task automatic run_instr();
      for (int k = 0; k < 8; k++) instr_cycle(k);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      {load_ir, load_ac, inc_pc, load_pc, mem_rd, mem_wr, halt} = 7'd0;
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   function automatic logic [7:0] instr(input opcode_t op, input logic [4:0] a);
      return {op, a};
   endfunction

   // ------------------------------------------------------------ sequence
   initial begin
      logic [2:0] op;
      logic [4:0] a;
      logic [6:0] s;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      step(7'd0);
      check("rst_opcode", 32'(opcode),      32'(HLT));
      check("rst_zero",   32'(zero),        32'd1);
      check("rst_addr",   32'(mem_addr),    32'd0);
      check("rst_wdata",  32'(mem_wdata),   32'd0);
      check("rst_halted", 32'(halted),      32'd0);
      check("rst_count",  32'(instr_count), 32'd0);

      // Directed program: LDA, ADD, XOR, JMP over a data word, LDA, STO.
      mem[0] = instr(LDA, 5'd20); mem[20] = 8'hF0;
      mem[1] = instr(ADD, 5'd4);  mem[4]  = 8'h20;
      mem[2] = instr(XOR, 5'd21); mem[21] = 8'h10;
      mem[3] = instr(JMP, 5'd5);
      mem[5] = instr(LDA, 5'd22); mem[22] = 8'hA5;
      mem[6] = instr(STO, 5'd9);
      mem[7] = instr(LDA, 5'd23); mem[23] = 8'h3C;
      run_instr();
      check("lda_ac", 32'(mem_wdata), 32'hF0);
      run_instr();
      check("add_ac",   32'(mem_wdata), 32'h10);
      check("add_zero", 32'(zero),      32'd0);
      run_instr();
      check("xor_ac",   32'(mem_wdata), 32'h00);
      check("xor_zero", 32'(zero),      32'd1);
      run_instr();
      run_instr();
      check("lda2_ac", 32'(mem_wdata), 32'hA5);
      for (int k = 0; k < 8; k++) instr_cycle(k);
      check("sto_addr",  32'(mem_addr),  32'd9);
      check("sto_wdata", 32'(mem_wdata), 32'hA5);
      check("sto_wr_en", 32'(mem_wr_en), 32'd1);
      step(7'd0);
      check("idle_addr", 32'(mem_addr), 32'd7);
      check("count6",    32'(instr_count), 32'd6);

      // AC=3C with PC=7, then reset mid-instruction.
      step(S_RD | S_LDIR);
      step(S_RD | S_LDIR);
      step(S_RD);
      step(S_RD | S_LDAC);
      check("pre_rst_ac",   32'(mem_wdata), 32'h3C);
      check("pre_rst_addr", 32'(mem_addr),  32'd23);
      #2 rst = 1'b1;
      #1;
      check("async_addr",   32'(mem_addr),  32'd0);
      check("async_wdata",  32'(mem_wdata), 32'd0);
      check("async_zero",   32'(zero),      32'd1);
      check("async_halted", 32'(halted),    32'd0);
      {load_ir, load_ac, inc_pc, load_pc, mem_rd, mem_wr, halt} = 7'd0;
      @(negedge clk);
      #2 rst = 1'b0;

      // PC wrap, then load_pc beating inc_pc.
      repeat (31) step(S_INC);
      check("pc31", 32'(mem_addr), 32'd31);
      step(S_INC);
      check("pc_wrap", 32'(mem_addr), 32'd0);
      do_reset();
      repeat (3) step(S_INC);
      mem[3] = instr(JMP, 5'd17);
      step(S_RD | S_LDIR);
      step(S_INC | S_LDPC);
      step(7'd0);
      check("ldpc_wins", 32'(mem_addr), 32'd17);

      // Halt freezes PC, write enable and the instruction counter.
      do_reset();
      step(S_HALT);
      check("halt_set", 32'(halted), 32'd1);
      step(S_INC | S_WR);
      check("halt_wr_en", 32'(mem_wr_en), 32'd0);
      check("halt_pc",    32'(mem_addr),  32'd0);
      step(S_RD | S_LDIR);
      step(7'd0);
      check("halt_count", 32'(instr_count), 32'd0);
      step(7'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      do_reset();
      step(7'd0);
      check("halt_clear", 32'(halted), 32'd0);

      // Five instructions: 16-bit counter reads 5, 2-bit counter holds at 3.
      for (int i = 0; i < 5; i++) mem[i] = instr(LDA, 5'(10 + i));
      repeat (5) run_instr();
      check("count5",  32'(instr_count), 32'd5);
      check("sat_max", 32'(sat_count),   32'd3);

      // Randomized instruction stream with occasional raw strobes and resets.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 19) == 0 || (m_halted && $urandom_range(0, 2) == 0)) begin
            do_reset();
         end else if ($urandom_range(0, 9) == 0) begin
            for (int j = 0; j < 4; j++) begin
               s = 7'($urandom);
               s[0] = ($urandom_range(0, 15) == 0);
               step(s);
            end
         end else begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd2;
            a = 5'($urandom);
            mem[a] = 8'($urandom);
            mem[m_pc] = {op, a};
            run_instr();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the sequence above is bounded, this only guards against a hang.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
